// File: rtl/lsu_if.sv
// Execute-side request, data-memory port and writeback/fault signals of the load/store unit.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        fault;
  logic        fault_cause;
  logic [31:0] fault_addr;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output wb_valid, wb_rd, wb_data, done, fault, fault_cause, fault_addr
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  wb_valid, wb_rd, wb_data, done, fault, fault_cause, fault_addr
  );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding op, registered memory request, extended load writeback.
// Faults are detected at accept and reported one cycle later without touching memory.
module lsu (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        fault_cause_q, fault_cause_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic        req_ready;
  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // A fault pulse blocks acceptance for its own cycle.
  assign req_ready = (state_q == IDLE) && !fault_q;
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (bus.req_we) begin
      illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    case (bus.req_funct3[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    lane_strb = 4'b1111;
    lane_data = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        lane_strb = 4'b0001 << bus.req_addr[1:0];
        lane_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        lane_strb = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        lane_strb = 4'b1111;
        lane_data = bus.req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = bus.mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    rd_d          = rd_q;
    mem_addr_d    = mem_addr_q;
    mem_wstrb_d   = mem_wstrb_q;
    mem_wdata_d   = mem_wdata_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    done_d        = 1'b0;
    fault_d       = 1'b0;
    fault_cause_d = fault_cause_q;
    fault_addr_d  = fault_addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal || misaligned) begin
            fault_d       = 1'b1;
            done_d        = 1'b1;
            fault_cause_d = illegal;
            fault_addr_d  = bus.req_addr;
          end else begin
            state_d     = REQ;
            we_d        = bus.req_we;
            funct3_d    = bus.req_funct3;
            off_d       = bus.req_addr[1:0];
            rd_d        = bus.req_rd;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_wstrb_d = bus.req_we ? lane_strb : 4'b0000;
            mem_wdata_d = lane_data;
          end
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          if (we_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          done_d     = 1'b1;
          wb_data_d  = ld_ext;
          wb_rd_d    = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      rd_q          <= 5'd0;
      mem_addr_q    <= 32'h0;
      mem_wstrb_q   <= 4'b0000;
      mem_wdata_q   <= 32'h0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'h0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= 1'b0;
      fault_addr_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      rd_q          <= rd_d;
      mem_addr_q    <= mem_addr_d;
      mem_wstrb_q   <= mem_wstrb_d;
      mem_wdata_q   <= mem_wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_we        = we_q;
  assign bus.mem_wstrb     = mem_wstrb_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.done          = done_q;
  assign bus.fault         = fault_q;
  assign bus.fault_cause   = fault_cause_q;
  assign bus.fault_addr    = fault_addr_q;
endmodule

// File: tb/tb_lsu.sv
// Directed vector table plus hand sequences for backpressure and reset while waiting.
module tb_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if bus();
  lsu u_dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        flt;
    logic        cause;
    logic [3:0]  strb;
    logic [31:0] mwdata;
    logic [31:0] wb;
  } vec_t;

  vec_t vecs [16];
  int checks = 0;
  int errors = 0;
  logic [31:0] last_wb = 32'h0;
  logic [4:0]  last_rd = 5'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the next op may be presented.
  task automatic run_vec(input vec_t v, input int idx);
    check($sformatf("v%0d_req_ready", idx), {31'h0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_rd     = v.rd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (v.flt) begin
      check($sformatf("v%0d_fault", idx), {31'h0, bus.fault}, 32'd1);
      check($sformatf("v%0d_fdone", idx), {31'h0, bus.done}, 32'd1);
      check($sformatf("v%0d_cause", idx), {31'h0, bus.fault_cause}, {31'h0, v.cause});
      check($sformatf("v%0d_faddr", idx), bus.fault_addr, v.addr);
      check($sformatf("v%0d_fmemv", idx), {31'h0, bus.mem_req_valid}, 32'd0);
      check($sformatf("v%0d_frdy0", idx), {31'h0, bus.req_ready}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_fclr", idx), {30'h0, bus.fault, bus.done}, 32'd0);
      check($sformatf("v%0d_fmemv2", idx), {31'h0, bus.mem_req_valid}, 32'd0);
    end else begin
      check($sformatf("v%0d_memv", idx), {31'h0, bus.mem_req_valid}, 32'd1);
      check($sformatf("v%0d_maddr", idx), bus.mem_addr, {v.addr[31:2], 2'b00});
      check($sformatf("v%0d_mwe", idx), {31'h0, bus.mem_we}, {31'h0, v.we});
      check($sformatf("v%0d_strb", idx), {28'h0, bus.mem_wstrb}, {28'h0, v.strb});
      if (v.we) check($sformatf("v%0d_mwdata", idx), bus.mem_wdata, v.mwdata);
      check($sformatf("v%0d_done_early", idx), {31'h0, bus.done}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_memv_off", idx), {31'h0, bus.mem_req_valid}, 32'd0);
      if (v.we) begin
        check($sformatf("v%0d_sdone", idx), {31'h0, bus.done}, 32'd1);
        check($sformatf("v%0d_swb", idx), {31'h0, bus.wb_valid}, 32'd0);
      end else begin
        check($sformatf("v%0d_wb_early", idx), {31'h0, bus.wb_valid}, 32'd0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = v.rdata;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 32'h0;
        check($sformatf("v%0d_wbv", idx), {31'h0, bus.wb_valid}, 32'd1);
        check($sformatf("v%0d_ldone", idx), {31'h0, bus.done}, 32'd1);
        check($sformatf("v%0d_wbdata", idx), bus.wb_data, v.wb);
        check($sformatf("v%0d_wbrd", idx), {27'h0, bus.wb_rd}, {27'h0, v.rd});
        last_wb = v.wb;
        last_rd = v.rd;
      end
    end
    if (v.we || v.flt) begin
      check($sformatf("v%0d_wb_hold", idx), bus.wb_data, last_wb);
      check($sformatf("v%0d_rd_hold", idx), {27'h0, bus.wb_rd}, {27'h0, last_rd});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'h0, bus.req_ready}, 32'd1);
    check({tag, "_pulses"}, {28'h0, bus.mem_req_valid, bus.wb_valid, bus.done, bus.fault}, 32'd0);
    check({tag, "_mwe"}, {31'h0, bus.mem_we}, 32'd0);
    check({tag, "_strb"}, {28'h0, bus.mem_wstrb}, 32'd0);
    check({tag, "_maddr"}, bus.mem_addr, 32'd0);
    check({tag, "_mwdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_wbdata"}, bus.wb_data, 32'd0);
    check({tag, "_wbrd"}, {27'h0, bus.wb_rd}, 32'd0);
    check({tag, "_fault_info"}, bus.fault_addr | {31'h0, bus.fault_cause}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //          we   f3      addr          wdata         rdata         rd  flt cause strb     mwdata        wb
    vecs[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 5'd5,  1'b0, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0,        5'd0,  1'b0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[2]  = '{1'b0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,        5'd4,  1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        5'd4,  1'b1, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 3'b100, 32'h0000_0104, 32'h1111_2222, 32'h0,        5'd0,  1'b1, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 3'b110, 32'h0000_0003, 32'h1111_2222, 32'h0,        5'd0,  1'b1, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 3'b000, 32'h0000_5001, 32'h1234_56A5, 32'h0,        5'd0,  1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[7]  = '{1'b1, 3'b010, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0,        5'd0,  1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[8]  = '{1'b0, 3'b100, 32'h0000_7002, 32'h0,        32'h11C3_2233, 5'd7,  1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_00C3};
    vecs[9]  = '{1'b0, 3'b001, 32'h0000_7002, 32'h0,        32'h9ABC_1234, 5'd31, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hFFFF_9ABC};
    vecs[10] = '{1'b0, 3'b010, 32'h0000_8000, 32'h0,        32'hCAFE_F00D, 5'd1,  1'b0, 1'b0, 4'b0000, 32'h0,        32'hCAFE_F00D};
    vecs[11] = '{1'b0, 3'b001, 32'h0000_7001, 32'h0,        32'h0,        5'd6,  1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 3'b001, 32'h0000_0011, 32'h0000_5555, 32'h0,        5'd0,  1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[13] = '{1'b0, 3'b101, 32'h0000_7000, 32'h0,        32'hFFFF_8765, 5'd2,  1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_8765};
    vecs[14] = '{1'b0, 3'b000, 32'h0000_7001, 32'h0,        32'h0000_7F00, 5'd3,  1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_007F};
    vecs[15] = '{1'b0, 3'b111, 32'h0000_0000, 32'h0,        32'h0,        5'd3,  1'b1, 1'b1, 4'b0000, 32'h0,        32'h0};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'd0;
    bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Stray response in IDLE must not produce a writeback.
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    check("stray_idle_rsp", {30'h0, bus.wb_valid, bus.done}, 32'd0);
    check("stray_idle_wbdata", bus.wb_data, last_wb);

    // LHU with three cycles of request backpressure.
    bus.mem_req_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b101;
    bus.req_addr = 32'h0000_4002; bus.req_rd = 5'd9; bus.req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d_memv", c), {31'h0, bus.mem_req_valid}, 32'd1);
      check($sformatf("bp%0d_fields", c), bus.mem_addr ^ {27'h0, bus.mem_we, bus.mem_wstrb}, 32'h0000_4000);
      check($sformatf("bp%0d_ready", c), {30'h0, bus.req_ready, bus.wb_valid}, 32'd0);
      bus.mem_rsp_valid = (c == 1);
      bus.mem_rdata     = 32'hDEAD_DEAD;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
    end
    bus.mem_req_ready = 1'b1;
    check("bp_memv_last", {31'h0, bus.mem_req_valid}, 32'd1);
    check("bp_addr_last", bus.mem_addr, 32'h0000_4000);
    @(negedge clk);
    check("bp_wait_memv", {31'h0, bus.mem_req_valid}, 32'd0);
    @(negedge clk);
    check("bp_wait_idle", {30'h0, bus.wb_valid, bus.done}, 32'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h8001_0000;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    check("bp_wbv", {30'h0, bus.wb_valid, bus.done}, 32'd3);
    check("bp_wbdata", bus.wb_data, 32'h0000_8001);
    check("bp_wbrd", {27'h0, bus.wb_rd}, 32'd9);
    @(negedge clk);

    // Reset while waiting for a load response, then a late response.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h0000_9000; bus.req_rd = 5'd12;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rw_in_wait", {31'h0, bus.mem_req_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_wait");
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h7777_7777;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    check("late_rsp_pulses", {30'h0, bus.wb_valid, bus.done}, 32'd0);
    check("late_rsp_wbdata", bus.wb_data, 32'h0);
    last_wb = 32'h0;
    last_rd = 5'd0;
    run_vec('{1'b0, 3'b010, 32'h0000_A000, 32'h0, 32'h1357_2468, 5'd20, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h1357_2468}, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
